uart_rx_os16: RTL and testbench
===============================

# uart_rx_os16

- UART receiver that recovers 8-bit frames from a serial line using 16x oversampling and mid-bit sampling.
- Frame format is 8N1 by default: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Complements the existing transmit path inside `top`: connects to the `txrx` loopback net or to an external pin.
- Pulses `rxdone` once per good frame and `frame_err` on a bad stop bit.

## Interface
Parameters:
- `CLK_FREQ`, 1_600_000: system clock frequency in Hz.
- `BAUD`, 10_000: line bit rate in baud.
- Derived `OSR_DIV` = CLK_FREQ/(BAUD*16), integer division. Must be ≥ 2; elaborate with `$error` otherwise.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `rx`  in  1  asynchronous serial input; idles high.
- `rxout`  out  8  last good received byte; held until the next good frame.
- `rxdone`  out  1  one-cycle pulse when `rxout` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.

## Operation
Input conditioning:
- `rx` passes through a 2-flop synchronizer, reset value 1, giving `rx_s`.
- A falling-edge detect compares `rx_s` with its previous value (registered, reset 1).

Oversampling tick:
- A tick counter counts 0..OSR_DIV-1 and emits a one-cycle `tick` at its terminal count.
- It is held at 0 in IDLE and restarts from 0 on start detection.

State machine (IDLE, START, DATA, PARITY, STOP, BREAK):
- IDLE: on falling edge of `rx_s` → START. Tick counter and sample counter cleared.
- START: on the 8th tick, sample `rx_s`. If 1 (glitch/false start) → IDLE with no output pulse. If 0 → DATA, sample counter cleared.
- DATA: every 16th tick, sample `rx_s` into shift bit `i`, i = 0..7, LSB first. After bit 7 → PARITY if compiled in, else STOP.
- PARITY: every 16th tick, sample the parity bit → STOP.
- STOP: on the 16th tick, sample `rx_s`.
  - If 1: load `rxout` from the shift register and pulse `rxdone` the next cycle → IDLE.
  - If 0: pulse `frame_err` the next cycle; `rxout` is unchanged → BREAK.
- BREAK: wait until `rx_s` = 1 → IDLE. Prevents a held-low line from retriggering.

Boundary conditions:
- A falling edge that arrives during the cycle of a STOP → IDLE transition is ignored. Detection resumes the following cycle.
- `rst` asserted mid-frame returns the FSM to IDLE and clears all counters and outputs.
- A back-to-back frame (new start bit immediately after the stop bit) is received without loss. The FSM is back in IDLE at mid-stop, so the next falling edge is caught.

## Timing
- Reset values: `rxout` = 8'h00, `rxdone` = 0, `frame_err` = 0, `parity_err` = 0, FSM = IDLE.
- Sample points, counted in ticks from start detection:
  - start bit at 8;
  - data bit i at 8+16(i+1);
  - parity at 152;
  - stop at 152 (no parity) or 168 (parity).
- Latency from the `rx` falling edge to `rxdone` rising is 152·OSR_DIV + 3 clocks (±1 for async phase). Defaults: 1523 ±1.
- `rxdone`, `frame_err` and `parity_err` are each exactly one clock wide.
- `rxout` is stable in the same cycle that `rxdone` is high.
- Throughput: one frame per 160·OSR_DIV clocks, or 176·OSR_DIV with parity. No backpressure: the consumer must take `rxout` before the next `rxdone`.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- When defined:
  - frame is 8E1; an even-parity bit sits between bit 7 and the stop bit;
  - `parity_err` pulses together with `rxdone` when the XOR of the data bits and the parity bit is 1;
  - `rxout` is still updated.
- When undefined: PARITY state is absent, `parity_err` is constant 0, frame is 8N1.

## Test plan
Defaults apply throughout: OSR_DIV = 10, 160 clocks per bit.
- Reset: hold `rst` for 3 cycles with `rx` = 1 → all outputs 0 and no pulses for 2000 cycles.
- Single frame: send 8'hA5 8N1 → `rxdone` pulses once, 1523 ±1 cycles after the start edge; `rxout` = 8'hA5; `frame_err` = 0.
- Back-to-back frames: send 8'h0A, 8'hC8, 8'h37 with no idle gap → three `rxdone` pulses, 1600 cycles apart; `rxout` values in order.
- Glitch and framing:
  - a 40-cycle low pulse on `rx` → no `rxdone` and no `frame_err`; FSM back in IDLE;
  - 8'h55 with stop bit forced 0 → `frame_err` pulse; `rxout` keeps its previous value; no `rxdone`.
- Mid-frame reset: assert `rst` at data bit 4 of 8'hFF, then send 8'h12 → only one `rxdone`, with `rxout` = 8'h12.
- With `UART_RX_PARITY_EN`:
  - 8'h03 with parity 0 → `rxdone`, `parity_err` = 0;
  - 8'h03 with parity 1 → `rxdone` and `parity_err` in the same cycle.

Source files
------------

// File: rtl/uart_rx_os16_if.sv
// Receive-side bundle of the 16x oversampling UART receiver: serial line in, byte and status pulses out.
// slave is the receiver's view; master is the line driver / byte consumer.
interface uart_rx_os16_if;
    logic       rx;
    logic [7:0] rxout;
    logic       rxdone;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rx,
        input  rxout,
        input  rxdone,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rx,
        output rxout,
        output rxdone,
        output frame_err,
        output parity_err
    );
endinterface

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampling with mid-bit sampling; all outputs registered.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity errors.
module uart_rx_os16 #(
    parameter int CLK_FREQ = 1_600_000,
    parameter int BAUD     = 10_000
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_os16_if.slave  bus
);

    localparam int OSR_DIV = CLK_FREQ / (BAUD * 16);
    localparam int TCW     = (OSR_DIV >= 2) ? $clog2(OSR_DIV) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OSR_DIV - 1);

    generate
        if (OSR_DIV < 2) begin : g_osr_chk
            $error("uart_rx_os16: CLK_FREQ/(BAUD*16) must be at least 2");
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;

    // Even parity: data bits XOR parity bit must be 0 on a clean frame.
    function automatic logic even_par_err(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;
`endif

    state_e           state_q, state_d;
    logic             sync1_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]       smp_cnt_q, smp_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rxout_q, rxout_d;
    logic             rxdone_q, rxdone_d;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic             tick_s;
    logic             fall_s;

    assign tick_s = (tick_cnt_q == TICK_LAST);
    assign fall_s = rx_prev_q & ~rx_s_q;

    // Two-flop synchronizer plus previous-value register for edge detection; idle-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= bus.rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Next-state, counter and output-pulse logic for the frame FSM.
    always_comb begin
        state_d     = state_q;
        smp_cnt_d   = smp_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rxout_d     = rxout_q;
        rxdone_d    = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        if ((state_q == ST_IDLE) || (state_q == ST_BREAK)) begin
            tick_cnt_d = '0;
        end else if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    smp_cnt_d  = 4'd0;
                end else begin
                    smp_cnt_d  = 4'd0;
                end
            end

            ST_START: begin
                if (tick_s) begin
                    if (smp_cnt_q == 4'd7) begin
                        smp_cnt_d = 4'd0;
                        bit_idx_d = 3'd0;
                        if (rx_s_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q;
                end
            end

            ST_DATA: begin
                if (tick_s) begin
                    if (smp_cnt_q == 4'd15) begin
                        smp_cnt_d = 4'd0;
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    if (smp_cnt_q == 4'd15) begin
                        smp_cnt_d = 4'd0;
                        par_d     = rx_s_q;
                        state_d   = ST_STOP;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q;
                end
            end
`endif

            // Leaving at mid-stop lets a back-to-back start edge be caught from IDLE.
            ST_STOP: begin
                if (tick_s) begin
                    if (smp_cnt_q == 4'd15) begin
                        smp_cnt_d = 4'd0;
                        if (rx_s_q) begin
                            rxout_d  = shift_q;
                            rxdone_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = even_par_err(shift_q, par_q);
`endif
                            state_d  = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q;
                end
            end

            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            smp_cnt_q   <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rxout_q     <= 8'h00;
            rxdone_q    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rxout_q     <= rxout_d;
            rxdone_q    <= rxdone_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.rxout     = rxout_q;
    assign bus.rxdone    = rxdone_q;
    assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: frames are queued when driven, checked when rxdone pulses.
module tb_uart_rx_os16;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OSR      = CLK_FREQ / (BAUD * 16);
    localparam int BIT_CLKS = OSR * 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN    = 1'b1;
    localparam int STOP_TICK = 168;
    localparam int FRAME_BITS = 11;
`else
    localparam bit PAR_EN    = 1'b0;
    localparam int STOP_TICK = 152;
    localparam int FRAME_BITS = 10;
`endif
    localparam int LAT        = STOP_TICK * OSR + 3;
    localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        int         start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_os16_if bus();

    uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   done_cnt = 0;
    int   fe_cnt = 0;
    int   last_done_cyc = 0;
    int   done_gap = 0;
    logic done_prev = 1'b0;
    logic fe_prev = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chk_cnt++;
        if (obs !== expv) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every rxdone.
    always @(negedge clk) begin
        if (bus.rxdone === 1'b1) begin
            done_cnt++;
            done_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
            check_val("rxdone_width", done_prev, 0);
            if (exp_q.size() == 0) begin
                check_val("rxdone_unexpected", exp_q.size(), 1);
            end else begin
                int lat;
                e   = exp_q.pop_front();
                lat = cyc - e.start_cyc;
                check_val("rxout", bus.rxout, e.data);
                check_val("parity_err", bus.parity_err, e.perr);
                check_val("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
            end
        end else if (bus.parity_err !== 1'b0) begin
            check_val("parity_err_alone", bus.parity_err, 0);
        end
        if (bus.frame_err === 1'b1) begin
            fe_cnt++;
            check_val("frame_err_width", fe_prev, 0);
        end
        done_prev = bus.rxdone;
        fe_prev   = bus.frame_err;
    end

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_bit,
                              input bit expect_ok);
        logic par_bit;
        par_bit = (^d) ^ bad_par;
        if (expect_ok) begin
            exp_q.push_back('{data: d, perr: (PAR_EN ? bad_par : 1'b0), start_cyc: cyc});
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par_bit);
        send_bit(stop_bit);
    endtask

    initial begin
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_rxout", bus.rxout, 8'h00);
        check_val("rst_rxdone", bus.rxdone, 0);
        check_val("rst_frame_err", bus.frame_err, 0);
        check_val("rst_parity_err", bus.parity_err, 0);
        repeat (2000) @(posedge clk);
        #1;
        check_val("idle_no_done", done_cnt, 0);
        check_val("idle_no_fe", fe_cnt, 0);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        check_val("single_done_cnt", done_cnt, 1);
        check_val("single_fe_cnt", fe_cnt, 0);

        send_frame(8'h0A, 1'b0, 1'b1, 1'b1);
        send_frame(8'hC8, 1'b0, 1'b1, 1'b1);
        send_frame(8'h37, 1'b0, 1'b1, 1'b1);
        check_val("b2b_gap", done_gap, FRAME_CLKS);
        repeat (500) @(posedge clk);
        #1;
        check_val("b2b_done_cnt", done_cnt, 4);

        // Short low pulse: false start must be rejected.
        bus.rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        check_val("glitch_done_cnt", done_cnt, 4);
        check_val("glitch_fe_cnt", fe_cnt, 0);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        bus.rx = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        check_val("ferr_fe_cnt", fe_cnt, 1);
        check_val("ferr_done_cnt", done_cnt, 4);
        check_val("ferr_rxout_held", bus.rxout, 8'h37);

        // Mid-frame reset during data bit 4 of 8'hFF.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus.rx = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("midrst_rxout", bus.rxout, 8'h00);
        repeat (BIT_CLKS * 6) @(posedge clk);
        #1;
        send_frame(8'h12, 1'b0, 1'b1, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        check_val("midrst_done_cnt", done_cnt, 5);
        check_val("midrst_rxout_final", bus.rxout, 8'h12);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b0, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        check_val("par_done_cnt", done_cnt, 7);
`endif

        check_val("sb_empty", exp_q.size(), 0);
        check_val("total_fe_cnt", fe_cnt, 1);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
